// File: rtl/rx_debounced.sv
// -----------------------------------------------------------------------------
// rx_debounced
//   UART receiver with an input synchronizer, 16x oversampling, mid-bit
//   sampling and a one-deep holding register with valid/ack handshake.
//
// Parameters
//   NB_DATA  data bits per frame (5..8), sent LSB first
//   SB_TICK  oversampling ticks spent in the stop period (16 = 1 stop bit,
//            32 = 2 stop bits); the stop sample is taken on the last tick
//
// Ports
//   i_clk        sole clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_tick       16x-baud strobe, one i_clk cycle wide
//   i_rx         serial line, idle high, asynchronous to i_clk
//   i_rx_ack     consumer has taken the held byte
//   o_data       last good byte, stable while o_rx_valid is high
//   o_rx_valid   held byte available (level)
//   o_frame_err  one-cycle pulse when the stop bit is sampled low
//   o_overrun    one-cycle pulse when a byte lands on an un-acked held byte
// -----------------------------------------------------------------------------
module rx_debounced #(
    parameter int NB_DATA = 8,
    parameter int SB_TICK = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_tick,
    input  logic               i_rx,
    input  logic               i_rx_ack,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_valid,
    output logic               o_frame_err,
    output logic               o_overrun
);

    // Sample counter must reach SB_TICK-1 (15 or 31) without wrapping.
    localparam int SW = $clog2(SB_TICK);
    // Bit counter only ever needs to hold 0..NB_DATA-1.
    localparam int NW = $clog2(NB_DATA);

    localparam logic [SW-1:0] S_ZERO      = {SW{1'b0}};
    localparam logic [SW-1:0] S_ONE       = SW'(1);
    localparam logic [SW-1:0] S_START_MID = SW'(7);
    localparam logic [SW-1:0] S_BIT_END   = SW'(15);
    localparam logic [SW-1:0] S_STOP_END  = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_ZERO      = {NW{1'b0}};
    localparam logic [NW-1:0] N_ONE       = NW'(1);
    localparam logic [NW-1:0] N_LAST      = NW'(NB_DATA - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic               rx_meta_r;
    logic               rx_sync_r;
    state_t             state_r;
    logic [SW-1:0]      s_r;
    logic [NW-1:0]      n_r;
    logic [NB_DATA-1:0] b_r;
    logic [NB_DATA-1:0] data_r;
    logic               rx_valid_r;
    logic               frame_err_r;
    logic               overrun_r;

    // Two-flop synchronizer; resets to the idle (high) line level so that
    // leaving reset never looks like a start bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= i_rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Receive FSM with its datapath and registered handshake/status outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r     <= IDLE;
            s_r         <= S_ZERO;
            n_r         <= N_ZERO;
            b_r         <= {NB_DATA{1'b0}};
            data_r      <= {NB_DATA{1'b0}};
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;

            // Ack clears the held byte; a completion in the same cycle
            // (STOP branch below) takes priority and keeps valid high.
            if (i_rx_ack && rx_valid_r) begin
                rx_valid_r <= 1'b0;
            end

            case (state_r)
                IDLE: begin
                    // Start detection does not wait for a tick.
                    if (!rx_sync_r) begin
                        state_r <= START;
                        s_r     <= S_ZERO;
                    end
                end

                START: begin
                    if (i_tick) begin
                        if (s_r == S_START_MID) begin
                            s_r <= S_ZERO;
                            if (!rx_sync_r) begin
                                state_r <= DATA;
                                n_r     <= N_ZERO;
                            end else begin
                                // Glitch shorter than half a bit: drop it.
                                state_r <= IDLE;
                            end
                        end else begin
                            s_r <= s_r + S_ONE;
                        end
                    end
                end

                DATA: begin
                    if (i_tick) begin
                        if (s_r == S_BIT_END) begin
                            s_r <= S_ZERO;
                            b_r <= {rx_sync_r, b_r[NB_DATA-1:1]};
                            if (n_r == N_LAST) begin
                                state_r <= STOP;
                            end else begin
                                n_r <= n_r + N_ONE;
                            end
                        end else begin
                            s_r <= s_r + S_ONE;
                        end
                    end
                end

                STOP: begin
                    if (i_tick) begin
                        if (s_r == S_STOP_END) begin
                            state_r <= IDLE;
                            s_r     <= S_ZERO;
                            if (rx_sync_r) begin
                                data_r     <= b_r;
                                rx_valid_r <= 1'b1;
                                overrun_r  <= rx_valid_r & ~i_rx_ack;
                            end else begin
                                // Bad stop bit: held byte and valid untouched.
                                frame_err_r <= 1'b1;
                            end
                        end else begin
                            s_r <= s_r + S_ONE;
                        end
                    end
                end

                default: begin
                    state_r <= IDLE;
                    s_r     <= S_ZERO;
                    n_r     <= N_ZERO;
                end
            endcase
        end
    end

    assign o_data      = data_r;
    assign o_rx_valid  = rx_valid_r;
    assign o_frame_err = frame_err_r;
    assign o_overrun   = overrun_r;

endmodule

// File: tb/tb_rx_debounced.sv
// -----------------------------------------------------------------------------
// tb_rx_debounced
//   Directed bench for rx_debounced. DUT a uses the defaults (8N1); DUT b uses
//   NB_DATA=7, SB_TICK=32. i_tick is high one cycle in four. The frame task
//   predicts the completion edge from the tick count the receiver must see
//   (8 start ticks + 16 per data bit + SB_TICK stop ticks, counted from the
//   third clock edge after the line falls, owing to the synchronizer).
// -----------------------------------------------------------------------------
module tb_rx_debounced;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_tick;
    logic       rx_a, rx_b;
    logic       ack_a, ack_b;
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic       valid_a, valid_b;
    logic       fe_a, fe_b;
    logic       ov_a, ov_b;

    logic [1:0] tick_div = 2'd0;
    int         n_tests  = 0;
    int         n_fail   = 0;
    int         fe_cnt_a = 0;
    int         ov_cnt_a = 0;
    int         fe_cnt_b = 0;
    int         ov_cnt_b = 0;

    rx_debounced #(.NB_DATA(8), .SB_TICK(16)) dut_a (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_tick(i_tick), .i_rx(rx_a),
        .i_rx_ack(ack_a), .o_data(data_a), .o_rx_valid(valid_a),
        .o_frame_err(fe_a), .o_overrun(ov_a)
    );

    rx_debounced #(.NB_DATA(7), .SB_TICK(32)) dut_b (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_tick(i_tick), .i_rx(rx_b),
        .i_rx_ack(ack_b), .o_data(data_b), .o_rx_valid(valid_b),
        .o_frame_err(fe_b), .o_overrun(ov_b)
    );

    always #5 i_clk = ~i_clk;

    // Tick divider: i_tick is stable between rising edges, so its value at a
    // falling edge is what the next rising edge samples.
    always @(posedge i_clk) tick_div <= tick_div + 2'd1;
    assign i_tick = (tick_div == 2'd0);

    // Count high cycles of each pulse output (one count per cycle high).
    always @(negedge i_clk) begin
        if (fe_a) fe_cnt_a <= fe_cnt_a + 1;
        if (ov_a) ov_cnt_a <= ov_cnt_a + 1;
        if (fe_b) fe_cnt_b <= fe_cnt_b + 1;
        if (ov_b) ov_cnt_b <= ov_cnt_b + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_line(input bit which, input logic v);
        if (which) rx_b = v;
        else       rx_a = v;
    endtask

    task automatic set_ack(input bit which, input logic v);
        if (which) ack_b = v;
        else       ack_a = v;
    endtask

    // Drive one frame from a falling edge. pred_c is the falling-edge index
    // just before the predicted completion edge; seen_c is the first index at
    // which a new valid, a frame error or an overrun is observed.
    task automatic send_frame(input bit which, input logic [7:0] data, input int nbits,
                              input int nstop, input logic stop_val, input bit ack_done,
                              output int pred_c, output int seen_c);
        int   tcnt   = 0;
        int   target = 8 + 16 * nbits + 16 * nstop;
        int   total  = (1 + nbits + nstop) * 64;
        logic v_prev;
        logic bitv;
        logic v, fe, ov;
        pred_c = -1;
        seen_c = -1;
        v_prev = which ? valid_b : valid_a;
        for (int c = 0; c < total; c++) begin
            if (c >= 3 && i_tick) begin
                tcnt++;
                if (tcnt == target) pred_c = c;
            end
            if (c < 64)                   bitv = 1'b0;
            else if (c < 64 * (1 + nbits)) bitv = data[(c / 64) - 1];
            else                          bitv = stop_val | (pred_c >= 0 && c > pred_c);
            set_line(which, bitv);
            set_ack(which, ack_done && (pred_c == c));
            @(negedge i_clk);
            if (which) begin v = valid_b; fe = fe_b; ov = ov_b; end
            else       begin v = valid_a; fe = fe_a; ov = ov_a; end
            if (seen_c < 0 && (fe || ov || (v && !v_prev))) seen_c = c + 1;
            v_prev = v;
        end
        set_line(which, 1'b1);
        set_ack(which, 1'b0);
    endtask

    task automatic pulse_ack_a();
        ack_a = 1'b1;
        @(negedge i_clk);
        ack_a = 1'b0;
    endtask

    int         pred, seen;
    int         fe0, ov0;
    logic [7:0] part;

    initial begin
        i_rst_n = 1'b0;
        rx_a = 1'b1; rx_b = 1'b1; ack_a = 1'b0; ack_b = 1'b0;
        repeat (3) @(negedge i_clk);

        // Reset state
        check("rst_data",  32'(data_a),  32'h0);
        check("rst_valid", 32'(valid_a), 32'h0);
        check("rst_fe",    32'(fe_a),    32'h0);
        check("rst_ov",    32'(ov_a),    32'h0);
        check("rst_valid_b", 32'(valid_b), 32'h0);
        i_rst_n = 1'b1;
        repeat (10) @(negedge i_clk);

        // 0xA5 8N1, then ack
        fe0 = fe_cnt_a; ov0 = ov_cnt_a;
        send_frame(1'b0, 8'hA5, 8, 1, 1'b1, 1'b0, pred, seen);
        repeat (64) @(negedge i_clk);
        check("a5_valid", 32'(valid_a), 32'h1);
        check("a5_data",  32'(data_a),  32'hA5);
        check("a5_time",  32'(seen),    32'(pred + 1));
        check("a5_fe",    32'(fe_cnt_a - fe0), 32'h0);
        check("a5_ov",    32'(ov_cnt_a - ov0), 32'h0);
        pulse_ack_a();
        check("a5_ack_valid", 32'(valid_a), 32'h0);
        check("a5_ack_data",  32'(data_a),  32'hA5);
        pulse_ack_a();
        check("ack_idle_valid", 32'(valid_a), 32'h0);

        // False start: low for 4 ticks
        fe0 = fe_cnt_a;
        rx_a = 1'b0;
        repeat (16) @(negedge i_clk);
        rx_a = 1'b1;
        repeat (200) @(negedge i_clk);
        check("fs_valid", 32'(valid_a), 32'h0);
        check("fs_fe",    32'(fe_cnt_a - fe0), 32'h0);

        // 0x3C with stop bit low
        fe0 = fe_cnt_a;
        send_frame(1'b0, 8'h3C, 8, 1, 1'b0, 1'b0, pred, seen);
        repeat (128) @(negedge i_clk);
        check("fe_pulse", 32'(fe_cnt_a - fe0), 32'h1);
        check("fe_time",  32'(seen),           32'(pred + 1));
        check("fe_valid", 32'(valid_a),        32'h0);
        check("fe_data",  32'(data_a),         32'hA5);

        // Break: low through a whole frame; then a second frame of all ones
        fe0 = fe_cnt_a; ov0 = ov_cnt_a;
        rx_a = 1'b0;
        repeat (660) @(negedge i_clk);
        rx_a = 1'b1;
        repeat (800) @(negedge i_clk);
        check("brk_fe",    32'(fe_cnt_a - fe0), 32'h1);
        check("brk_valid", 32'(valid_a),        32'h1);
        check("brk_data",  32'(data_a),         32'hFF);
        check("brk_ov",    32'(ov_cnt_a - ov0), 32'h0);
        pulse_ack_a();
        check("brk_ack", 32'(valid_a), 32'h0);

        // Overrun: 0x11 then 0x22 without ack
        ov0 = ov_cnt_a;
        send_frame(1'b0, 8'h11, 8, 1, 1'b1, 1'b0, pred, seen);
        repeat (32) @(negedge i_clk);
        check("ov1_data", 32'(data_a), 32'h11);
        send_frame(1'b0, 8'h22, 8, 1, 1'b1, 1'b0, pred, seen);
        repeat (32) @(negedge i_clk);
        check("ov_pulse", 32'(ov_cnt_a - ov0), 32'h1);
        check("ov_time",  32'(seen),           32'(pred + 1));
        check("ov_data",  32'(data_a),         32'h22);
        check("ov_valid", 32'(valid_a),        32'h1);

        // 0x44 with ack exactly on the completion edge: no overrun
        ov0 = ov_cnt_a;
        send_frame(1'b0, 8'h44, 8, 1, 1'b1, 1'b1, pred, seen);
        repeat (32) @(negedge i_clk);
        check("ackc_ov",    32'(ov_cnt_a - ov0), 32'h0);
        check("ackc_data",  32'(data_a),         32'h44);
        check("ackc_valid", 32'(valid_a),        32'h1);

        // Reset during data bit 3 of 0x5A
        part = 8'h5A;
        for (int c = 0; c < 64 * 4 + 32; c++) begin
            if (c < 64) rx_a = 1'b0;
            else        rx_a = part[(c / 64) - 1];
            @(negedge i_clk);
        end
        i_rst_n = 1'b0;
        #1;
        check("mrst_data",  32'(data_a),  32'h0);
        check("mrst_valid", 32'(valid_a), 32'h0);
        check("mrst_fe",    32'(fe_a),    32'h0);
        check("mrst_ov",    32'(ov_a),    32'h0);
        rx_a = 1'b1;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (800) @(negedge i_clk);
        check("mrst_discard", 32'(valid_a), 32'h0);
        fe0 = fe_cnt_a;
        send_frame(1'b0, 8'h5A, 8, 1, 1'b1, 1'b0, pred, seen);
        repeat (32) @(negedge i_clk);
        check("5a_valid", 32'(valid_a), 32'h1);
        check("5a_data",  32'(data_a),  32'h5A);
        check("5a_time",  32'(seen),    32'(pred + 1));
        check("5a_fe",    32'(fe_cnt_a - fe0), 32'h0);

        // DUT b: 7 data bits, 2 stop bits, 0x41
        send_frame(1'b1, 8'h41, 7, 2, 1'b1, 1'b0, pred, seen);
        repeat (32) @(negedge i_clk);
        check("b41_valid", 32'(valid_b),  32'h1);
        check("b41_data",  32'(data_b),   32'h41);
        check("b41_time",  32'(seen),     32'(pred + 1));
        check("b41_fe",    32'(fe_cnt_b), 32'h0);
        check("b41_ov",    32'(ov_cnt_b), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
